// File: rtl/hive_stack_data_ring.sv
// hive_stack_data_ring
// --------------------
// Data storage for the per-thread LIFO stacks of the 8-thread hive core.
// The stack level logic presents, at stage 6, the thread ID, its post-push/pop
// level and a push write enable. This block writes the push data at the level
// address and re-reads that same address, so the new top-of-stack comes back
// to the same thread at stage 0 of its next ring pass, two cycles later.
//
// Optional feature (macro HIVE_STK_PARITY_EN): each entry carries an even
// parity bit, and a read parity mismatch is reported on par_er_0_o. When the
// macro is undefined, par_er_0_o is tied low and no parity logic is built.
//
// Ports:
//   clk_i       in   1          clock
//   rst_i       in   1          asynchronous reset, active-low
//   thd_6_i     in   THRD_W     thread ID occupying stage 6
//   level_6_i   in   STK_LVL_W  post-pop/push stack level (0 = empty)
//   wr_6_i      in   1          push write enable
//   data_6_i    in   DATA_W     push data
//   data_0_o    out  DATA_W     top-of-stack data for the stage-0 thread
//   empty_0_o   out  1          stack empty flag for the stage-0 thread
//   par_er_0_o  out  1          read parity error pulse (0 without parity)
module hive_stack_data_ring #(
  parameter int THRD_W    = 3,
  parameter int STK_LVL_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [THRD_W-1:0]    thd_6_i,
  input  logic [STK_LVL_W-1:0] level_6_i,
  input  logic                 wr_6_i,
  input  logic [DATA_W-1:0]    data_6_i,
  output logic [DATA_W-1:0]    data_0_o,
  output logic                 empty_0_o,
  output logic                 par_er_0_o
);

  // Each thread owns 2^(STK_LVL_W-1) entries; the thread ID forms the upper
  // address bits, so no level value can reach another thread's storage.
  localparam int ADDR_W = THRD_W + STK_LVL_W - 1;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef HIVE_STK_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

`ifdef HIVE_STK_PARITY_EN
  // Even parity: the stored bit makes the XOR of the whole word zero.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  logic [ADDR_W-1:0] w_addr_6;
  logic [MEM_W-1:0]  w_wr_word_6;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [MEM_W-1:0]  r_rd_7;
  logic              r_empty_7;
  logic [DATA_W-1:0] r_data_0;
  logic              r_empty_0;

  // Level MSB is dropped: a full stack (level 2^(STK_LVL_W-1)) uses slot 0,
  // and a wrapped all-ones level simply addresses the top slot.
  assign w_addr_6 = {thd_6_i, level_6_i[STK_LVL_W-2:0]};

`ifdef HIVE_STK_PARITY_EN
  assign w_wr_word_6 = {even_par(data_6_i), data_6_i};
`else
  assign w_wr_word_6 = data_6_i;
`endif

  // Stack memory write port; contents are never reset, writes blocked in reset.
  always_ff @(posedge clk_i) begin
    if (wr_6_i && rst_i) begin
      r_mem[w_addr_6] <= w_wr_word_6;
    end
  end

  // Stage 7 read register; read and write share one address, so a push
  // returns its own data (write-first).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_7    <= {MEM_W{1'b0}};
      r_empty_7 <= 1'b1;
    end else begin
      r_rd_7    <= wr_6_i ? w_wr_word_6 : r_mem[w_addr_6];
      r_empty_7 <= (level_6_i == {STK_LVL_W{1'b0}});
    end
  end

  // Stage 0 output registers; an empty stack presents zero data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data_0  <= {DATA_W{1'b0}};
      r_empty_0 <= 1'b1;
    end else begin
      r_data_0  <= r_empty_7 ? {DATA_W{1'b0}} : r_rd_7[DATA_W-1:0];
      r_empty_0 <= r_empty_7;
    end
  end

  assign data_0_o  = r_data_0;
  assign empty_0_o = r_empty_0;

`ifdef HIVE_STK_PARITY_EN
  logic w_par_mis_7;
  logic r_par_er_0;

  // Any odd number of flipped bits makes the whole stored word XOR to one.
  assign w_par_mis_7 = ^r_rd_7;

  // Parity error pulse, aligned with data_0_o and masked for empty stacks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_par_er_0 <= 1'b0;
    end else begin
      r_par_er_0 <= w_par_mis_7 & ~r_empty_7;
    end
  end

  assign par_er_0_o = r_par_er_0;
`else
  assign par_er_0_o = 1'b0;
`endif

endmodule

// File: tb/tb_hive_stack_data_ring.sv
// Directed bench for hive_stack_data_ring: each vector is applied at stage 6
// and its stage-0 result is compared two clock edges later.
module tb_hive_stack_data_ring;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [2:0]  thd_6_i = 3'd0;
  logic [4:0]  level_6_i = 5'd0;
  logic        wr_6_i = 1'b0;
  logic [31:0] data_6_i = 32'd0;
  logic [31:0] data_0_o;
  logic        empty_0_o;
  logic        par_er_0_o;

  int n_checks = 0;
  int n_errors = 0;

  hive_stack_data_ring #(.THRD_W(3), .STK_LVL_W(5), .DATA_W(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .thd_6_i    (thd_6_i),
    .level_6_i  (level_6_i),
    .wr_6_i     (wr_6_i),
    .data_6_i   (data_6_i),
    .data_0_o   (data_0_o),
    .empty_0_o  (empty_0_o),
    .par_er_0_o (par_er_0_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] thd, input logic [4:0] lvl, input logic wr,
                       input logic [31:0] d);
    thd_6_i   = thd;
    level_6_i = lvl;
    wr_6_i    = wr;
    data_6_i  = d;
  endtask

  task automatic idle();
    drive(3'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_d, input logic exp_e,
                           input logic exp_p);
    check({tag, ".data"}, data_0_o, exp_d);
    check({tag, ".empty"}, {31'd0, empty_0_o}, {31'd0, exp_e});
    check({tag, ".par"}, {31'd0, par_er_0_o}, {31'd0, exp_p});
  endtask

  // One stage-6 vector followed by an idle slot; result checked 2 edges later.
  task automatic op(input string tag, input logic [2:0] thd, input logic [4:0] lvl,
                    input logic wr, input logic [31:0] d,
                    input logic [31:0] exp_d, input logic exp_e, input logic exp_p);
    drive(thd, lvl, wr, d);
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
    check_out(tag, exp_d, exp_e, exp_p);
  endtask

  initial begin
    // Reset held for 3 cycles, then released with idle inputs.
    idle();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_out("rst_hold", 32'd0, 1'b1, 1'b0);
    end
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_out("rst_post", 32'd0, 1'b1, 1'b0);
    end

    // Single push, write-first return of the pushed data.
    op("push_t2", 3'd2, 5'd1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);

    // Thread 5 push/push/pop/pop.
    op("t5_push1", 3'd5, 5'd1, 1'b1, 32'h11, 32'h11, 1'b0, 1'b0);
    op("t5_push2", 3'd5, 5'd2, 1'b1, 32'h22, 32'h22, 1'b0, 1'b0);
    op("t5_pop1",  3'd5, 5'd1, 1'b0, 32'h0,  32'h11, 1'b0, 1'b0);
    op("t5_pop0",  3'd5, 5'd0, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0);

    // Pop and push in the same cycle overwrites the top entry.
    op("t3_push",   3'd3, 5'd4, 1'b1, 32'hA, 32'hA, 1'b0, 1'b0);
    op("t3_poppsh", 3'd3, 5'd4, 1'b1, 32'hB, 32'hB, 1'b0, 1'b0);
    op("t3_reread", 3'd3, 5'd4, 1'b0, 32'h0, 32'hB, 1'b0, 1'b0);

    // Full wrap into slot 0 and thread isolation.
    op("t0_full",   3'd0, 5'd16, 1'b1, 32'hC0C0C0C0, 32'hC0C0C0C0, 1'b0, 1'b0);
    op("t6_top",    3'd6, 5'd15, 1'b1, 32'h6F6F6F6F, 32'h6F6F6F6F, 1'b0, 1'b0);
    op("t7_full",   3'd7, 5'd16, 1'b1, 32'hFF, 32'hFF, 1'b0, 1'b0);
    op("t7_slot0",  3'd7, 5'd16, 1'b0, 32'h0, 32'hFF, 1'b0, 1'b0);
    op("t0_iso",    3'd0, 5'd16, 1'b0, 32'h0, 32'hC0C0C0C0, 1'b0, 1'b0);
    op("t6_iso",    3'd6, 5'd15, 1'b0, 32'h0, 32'h6F6F6F6F, 1'b0, 1'b0);

    // Unprotected empty pop: level wraps to all-ones, slot 15 read, not empty.
    op("t4_top",    3'd4, 5'd15, 1'b1, 32'h4444AAAA, 32'h4444AAAA, 1'b0, 1'b0);
    op("t4_wrap",   3'd4, 5'd31, 1'b0, 32'h0, 32'h4444AAAA, 1'b0, 1'b0);

    // Back-to-back vectors: exactly two cycles of latency, one result per cycle.
    drive(3'd5, 5'd2, 1'b0, 32'h0);
    @(negedge clk_i);
    drive(3'd2, 5'd1, 1'b0, 32'h0);
    @(negedge clk_i);
    drive(3'd5, 5'd0, 1'b0, 32'h0);
    check_out("b2b_a", 32'h22, 1'b0, 1'b0);
    @(negedge clk_i);
    idle();
    check_out("b2b_b", 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk_i);
    check_out("b2b_c", 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a valid result in flight.
    drive(3'd2, 5'd1, 1'b0, 32'h0);
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check_out("rst_async", 32'h0, 1'b1, 1'b0);
    // A push presented during reset must not reach the memory.
    @(negedge clk_i);
    drive(3'd2, 5'd1, 1'b1, 32'h55555555);
    @(negedge clk_i);
    idle();
    check_out("rst_mid", 32'h0, 1'b1, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    op("rst_noWr", 3'd2, 5'd1, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

`ifdef HIVE_STK_PARITY_EN
    // Corrupt one stored bit of thread 1 level 3 (address {1,3} = 19).
    op("t1_push", 3'd1, 5'd3, 1'b1, 32'h00000F0F, 32'h00000F0F, 1'b0, 1'b0);
    dut.r_mem[19][0] = ~dut.r_mem[19][0];
    op("t1_parerr", 3'd1, 5'd3, 1'b0, 32'h0, 32'h00000F0E, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("t1_pulse", 32'h0, 1'b1, 1'b0);
    op("t1_lvl0", 3'd1, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
